rd_tag_alloc: RTL and testbench
===============================

Name: rd_tag_alloc

Overview:
- Per-destination-register write-tag allocator and outstanding-write tracker for the ID stage.
- Hands out the TAG_WIDTH tag carried by an issuing instruction with rd_wr_en. The tag is written to the register file as the new tag and travels with rd_wr_tag down the pipe.
- Counts in-flight writes per architectural register. Refuses allocation when one more write would alias a tag that is still in flight. ID stage folds ~alloc_gnt into its stall.

Parameters:
- TAG_WIDTH, 2, tag width. Max in-flight writes per register = 2^TAG_WIDTH - 1.

Ports:
- clk  input  1  core clock
- reset_n  input  1  asynchronous active-low reset
- alloc_req  input  1  ID issues an instruction with rd_wr_en (already qualified by ready_id & ~flush_D)
- alloc_addr  input  5  destination register of issuing instruction
- alloc_gnt  output  1  allocation accepted this cycle (combinational)
- alloc_tag  output  TAG_WIDTH  tag for issuing instruction (combinational, valid when alloc_gnt)
- retire_en  input  1  WB register-file write completes
- retire_addr  input  5  WB destination register
- retire_tag  input  TAG_WIDTH  WB tag
- kill_en  input  1  an in-flight writer was squashed after allocation (flush of EX)
- kill_addr  input  5  destination register of squashed writer
- pending_any  output  1  at least one register has outstanding count > 0 (registered state, comb OR)
- alloc_err  output  1  sticky protocol-error flag

Behaviour:
- State per register r = 1..31:
  - next_tag[r] (TAG_WIDTH bits)
  - cnt[r] (TAG_WIDTH bits; range 0..2^TAG_WIDTH-1)
  - r = 0 has no state.
- Reset (async, reset_n low):
  - all next_tag = 0, all cnt = 0, alloc_err = 0
  - outputs: alloc_gnt = 0 unless alloc_req, pending_any = 0.
  - Reset mid-operation discards all tracking; no pending write survives reset.
- Grant (combinational, zero latency):
  - alloc_addr == 0: alloc_gnt = alloc_req, alloc_tag = 0, no state change.
  - otherwise: alloc_gnt = alloc_req & (cnt[a] != 2^TAG_WIDTH-1); alloc_tag = next_tag[a].
  - The retire/kill of the same cycle is NOT credited toward the grant (no comb path from release ports to alloc_gnt).
- Update on posedge clk, evaluated per register r != 0:
  - inc = alloc_gnt & alloc_addr == r (alloc_req low means no inc).
  - dec = (retire_en & retire_addr == r) + (kill_en & kill_addr == r), range 0..2.
  - cnt[r] <= cnt[r] + inc - dec.
  - next_tag[r] <= next_tag[r] + inc, modulo 2^TAG_WIDTH, wraps 3 -> 0 for TAG_WIDTH = 2.
  - Kill does not rewind next_tag; skipped tags are never reissued while the older writer is alive.
  - Simultaneous alloc and retire on the same r: cnt unchanged, next_tag advances.
- Retire/kill with addr == 0 are ignored.
- Error detection (alloc_err set next cycle, stays 1 until reset):
  - retire or kill to r with cnt[r] + inc < dec (underflow). cnt saturates at 0 instead of wrapping.
  - retire_en with retire_tag != oldest[r], where oldest[r] = next_tag[r] - cnt[r] mod 2^TAG_WIDTH. Checked only when no kill hits the same r in the same cycle; the count is still decremented.
- pending_any = OR over r of (cnt[r] != 0).

Test Plan:
- Reset, then alloc_req = 1, addr = 5 for three consecutive cycles -> alloc_tag 0, 1, 2, alloc_gnt = 1 each. Fourth cycle alloc_gnt = 0 (cnt = 3) and alloc_tag shows 3. pending_any = 1.
- With cnt[5] = 3, retire_en addr 5 tag 0 in the same cycle as alloc_req addr 5 -> alloc_gnt = 0 that cycle. Next cycle cnt = 2 and alloc grants tag 3. Following alloc grants tag 0 (wrap) only after another retire.
- Alloc addr 7 gets tag 0; next cycle retire_en addr 7 tag 0 together with alloc addr 7 -> grant tag 1, cnt[7] stays 1, alloc_err = 0.
- Alloc addr 0 repeatedly (10 cycles) -> alloc_gnt = 1, alloc_tag = 0 every cycle. pending_any stays 0. Retire addr 0 -> no alloc_err.
- Alloc addr 3 twice (tags 0, 1), kill addr 3 and retire addr 3 tag 0 same cycle -> cnt[3] = 0, pending_any = 0 next cycle. Next alloc addr 3 gets tag 2.
- Retire addr 9 with cnt[9] = 0 -> alloc_err = 1 next cycle, cnt[9] stays 0. Assert reset_n low mid-run -> alloc_err = 0 and all counts cleared asynchronously.

Source files
------------

// File: rtl/rd_tag_alloc.sv
`default_nettype none
// ============================================================================
// Module   : rd_tag_alloc
// Brief    : Per-register write-tag allocator and in-flight write tracker (ID).
// Revision : 1.0
// ============================================================================
module rd_tag_alloc #(
    parameter int unsigned TAG_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 alloc_req,
    input  logic [4:0]           alloc_addr,
    output logic                 alloc_gnt,
    output logic [TAG_WIDTH-1:0] alloc_tag,
    input  logic                 retire_en,
    input  logic [4:0]           retire_addr,
    input  logic [TAG_WIDTH-1:0] retire_tag,
    input  logic                 kill_en,
    input  logic [4:0]           kill_addr,
    output logic                 pending_any,
    output logic                 alloc_err
);

    localparam logic [TAG_WIDTH-1:0] C_CNT_MAX = '1;

    // Entry 0 models x0: never busy, always tag 0.
    logic [TAG_WIDTH-1:0] w_cnt [32];
    logic [TAG_WIDTH-1:0] w_tag [32];
    logic [31:1]          w_pend;
    logic [31:1]          w_err;
    logic                 r_err;

    assign w_cnt[0] = '0;
    assign w_tag[0] = '0;

    // Grant looks only at registered counts; same-cycle releases are not credited.
    assign alloc_gnt   = alloc_req & ((alloc_addr == 5'd0) | (w_cnt[alloc_addr] != C_CNT_MAX));
    assign alloc_tag   = w_tag[alloc_addr];
    assign pending_any = |w_pend;
    assign alloc_err   = r_err;

    generate
        for (genvar r = 1; r < 32; r++) begin : g_reg
            logic [TAG_WIDTH-1:0] r_cnt;
            logic [TAG_WIDTH-1:0] r_next_tag;
            logic                 w_inc;
            logic                 w_ret;
            logic                 w_kill;
            logic [TAG_WIDTH+1:0] w_sum;
            logic [TAG_WIDTH+1:0] w_dec;
            logic                 w_under;
            logic [TAG_WIDTH-1:0] w_oldest;
            logic                 w_tag_err;
            logic [TAG_WIDTH-1:0] w_cnt_nxt;

            assign w_inc  = alloc_gnt & (alloc_addr == 5'(r));
            assign w_ret  = retire_en & (retire_addr == 5'(r));
            assign w_kill = kill_en & (kill_addr == 5'(r));

            assign w_sum   = {2'b00, r_cnt} + (TAG_WIDTH+2)'(w_inc);
            assign w_dec   = (TAG_WIDTH+2)'(w_ret) + (TAG_WIDTH+2)'(w_kill);
            assign w_under = (w_sum < w_dec);

            // Oldest live tag; a concurrent kill makes the retiring tag ambiguous.
            assign w_oldest  = r_next_tag - r_cnt;
            assign w_tag_err = w_ret & ~w_kill & (retire_tag != w_oldest);

            assign w_cnt_nxt = w_under ? '0 :
                               (r_cnt + TAG_WIDTH'(w_inc) - TAG_WIDTH'(w_ret) - TAG_WIDTH'(w_kill));

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt      <= '0;
                    r_next_tag <= '0;
                end else begin
                    r_cnt      <= w_cnt_nxt;
                    r_next_tag <= r_next_tag + TAG_WIDTH'(w_inc);
                end
            end

            assign w_cnt[r]  = r_cnt;
            assign w_tag[r]  = r_next_tag;
            assign w_pend[r] = (r_cnt != '0);
            assign w_err[r]  = w_under | w_tag_err;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | (|w_err);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rd_tag_alloc.sv
`default_nettype none
// ============================================================================
// Module   : tb_rd_tag_alloc
// Brief    : Directed scoreboard bench for rd_tag_alloc.
// Revision : 1.0
// ============================================================================
module tb_rd_tag_alloc;

    logic       clk;
    logic       reset_n;
    logic       alloc_req;
    logic [4:0] alloc_addr;
    logic       alloc_gnt;
    logic [1:0] alloc_tag;
    logic       retire_en;
    logic [4:0] retire_addr;
    logic [1:0] retire_tag;
    logic       kill_en;
    logic [4:0] kill_addr;
    logic       pending_any;
    logic       alloc_err;

    typedef struct packed {
        logic       gnt;
        logic [1:0] tag;
        logic       ctag;
        logic       pend;
        logic       err;
        logic [7:0] id;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   step_id  = 0;

    rd_tag_alloc #(.TAG_WIDTH(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .alloc_req   (alloc_req),
        .alloc_addr  (alloc_addr),
        .alloc_gnt   (alloc_gnt),
        .alloc_tag   (alloc_tag),
        .retire_en   (retire_en),
        .retire_addr (retire_addr),
        .retire_tag  (retire_tag),
        .kill_en     (kill_en),
        .kill_addr   (kill_addr),
        .pending_any (pending_any),
        .alloc_err   (alloc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step=%0d actual=%0d expected=%0d", name, id, act, exp);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle, after inputs and state have settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("alloc_gnt", int'(e.id), {1'b0, alloc_gnt}, {1'b0, e.gnt});
                if (e.ctag) chk("alloc_tag", int'(e.id), alloc_tag, e.tag);
                chk("pending_any", int'(e.id), {1'b0, pending_any}, {1'b0, e.pend});
                chk("alloc_err", int'(e.id), {1'b0, alloc_err}, {1'b0, e.err});
            end
        end
    end

    task automatic step(
        input logic req, input logic [4:0] addr,
        input logic ren, input logic [4:0] raddr, input logic [1:0] rtag,
        input logic ken, input logic [4:0] kaddr,
        input logic egnt, input logic [1:0] etag, input logic ctag,
        input logic epend, input logic eerr
    );
        exp_t e;
        alloc_req   = req;  alloc_addr  = addr;
        retire_en   = ren;  retire_addr = raddr; retire_tag = rtag;
        kill_en     = ken;  kill_addr   = kaddr;
        e.gnt = egnt; e.tag = etag; e.ctag = ctag; e.pend = epend; e.err = eerr;
        step_id++;
        e.id = 8'(step_id);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        alloc_req = 0; alloc_addr = 0; retire_en = 0; retire_addr = 0; retire_tag = 0;
        kill_en = 0; kill_addr = 0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state while still in reset
        step(0,0, 0,0,0, 0,0,  0,0,0, 0,0);
        reset_n = 1'b1;

        // Fill r5, then hit the in-flight limit
        step(1,5, 0,0,0, 0,0,  1,0,1, 0,0);
        step(1,5, 0,0,0, 0,0,  1,1,1, 1,0);
        step(1,5, 0,0,0, 0,0,  1,2,1, 1,0);
        step(1,5, 0,0,0, 0,0,  0,3,1, 1,0);
        // Retire in the same cycle is not credited to the grant
        step(1,5, 1,5,0, 0,0,  0,3,1, 1,0);
        step(1,5, 0,0,0, 0,0,  1,3,1, 1,0);
        step(1,5, 0,0,0, 0,0,  0,0,1, 1,0);
        step(0,0, 1,5,1, 0,0,  0,0,0, 1,0);
        step(1,5, 0,0,0, 0,0,  1,0,1, 1,0);
        step(0,0, 1,5,2, 0,0,  0,0,0, 1,0);
        step(0,0, 1,5,3, 0,0,  0,0,0, 1,0);
        step(0,0, 1,5,0, 0,0,  0,0,0, 1,0);

        // Concurrent alloc + retire on r7
        step(1,7, 0,0,0, 0,0,  1,0,1, 0,0);
        step(1,7, 1,7,0, 0,0,  1,1,1, 1,0);
        step(0,0, 1,7,1, 0,0,  0,0,0, 1,0);

        // x0: always granted, tag 0, no state; releases to x0 ignored
        for (int i = 0; i < 10; i++) begin
            step(1,0, (i == 5),0,2'd3, (i == 6),0,  1,0,1, 0,0);
        end
        step(0,0, 0,0,0, 0,0,  0,0,0, 0,0);

        // Kill and retire together drain r3; next_tag is not rewound
        step(1,3, 0,0,0, 0,0,  1,0,1, 0,0);
        step(1,3, 0,0,0, 0,0,  1,1,1, 1,0);
        step(0,0, 1,3,0, 1,3,  0,0,0, 1,0);
        step(1,3, 0,0,0, 0,0,  1,2,1, 0,0);
        // Wrong retire tag (oldest is 2)
        step(0,0, 1,3,0, 0,0,  0,0,0, 1,0);
        step(0,0, 0,0,0, 0,0,  0,0,0, 0,1);

        // Async reset mid-cycle clears the sticky error
        reset_n = 1'b0;
        #1;
        step(0,0, 0,0,0, 0,0,  0,0,0, 0,0);
        reset_n = 1'b1;

        // Underflow on r9 flags error, count saturates at 0
        step(1,3, 0,0,0, 0,0,  1,0,1, 0,0);
        step(0,0, 1,9,0, 0,0,  0,0,0, 1,0);
        step(1,9, 0,0,0, 0,0,  1,0,1, 1,1);
        step(0,0, 0,0,0, 1,9,  0,0,0, 1,1);
        step(0,0, 0,0,0, 1,3,  0,0,0, 1,1);
        step(0,0, 0,0,0, 0,0,  0,0,0, 0,1);
        step(1,9, 0,0,0, 0,0,  1,1,1, 0,1);

        // Reset with a write pending: everything clears without a clock edge
        reset_n = 1'b0;
        #1;
        step(1,9, 0,0,0, 0,0,  1,0,1, 0,0);
        reset_n = 1'b1;
        step(0,0, 0,0,0, 0,0,  0,0,0, 0,0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
